// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU result mux.
// Captures {data, sel, carry} plus derived zero/negative flags into a
// 2-entry skid FIFO with a valid/ready handshake, and counts pops.
// Optional feature: define ALU_RESULT_PARITY_EN to add out_parity
// (even parity of the head data, stored per entry at push time).
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | no entries held, out_valid=0, head regs cleared
// ONE   | head entry valid, second slot free
// FULL  | head and second entry valid, in_ready=0
module alu_result_stage #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic [CNT_W-1:0] xfer_count
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic         push, pop;
  logic         head_ld_in, head_ld_e1, head_clr, e1_ld, e1_clr;
  logic         in_zero, in_neg;

  logic [W-1:0] h_data, e1_data;
  logic [1:0]   h_sel, e1_sel;
  logic         h_carry, e1_carry;
  logic         h_zero, e1_zero;
  logic         h_neg, e1_neg;
`ifdef ALU_RESULT_PARITY_EN
  logic         in_par;
  logic         h_par, e1_par;
`endif

  // Handshake and flag derivation; in_ready depends on the state register only
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_zero   = (in_data == '0);
  assign in_neg    = in_data[W-1];
`ifdef ALU_RESULT_PARITY_EN
  assign in_par    = ^in_data;
`endif

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state and storage-control decode
  always_comb begin
    state_nxt  = state;
    head_ld_in = 1'b0;
    head_ld_e1 = 1'b0;
    head_clr   = 1'b0;
    e1_ld      = 1'b0;
    e1_clr     = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          head_ld_in = 1'b1;
          state_nxt  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // old head leaves, new entry becomes head
          head_ld_in = 1'b1;
        end else if (push) begin
          e1_ld     = 1'b1;
          state_nxt = FULL;
        end else if (pop) begin
          // clear head so flags read 0 while empty
          head_clr  = 1'b1;
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_ld_e1 = 1'b1;
          e1_clr     = 1'b1;
          state_nxt  = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Head entry: loaded from input, promoted from second entry, or cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data  <= '0;
      h_sel   <= '0;
      h_carry <= 1'b0;
      h_zero  <= 1'b0;
      h_neg   <= 1'b0;
    end else if (head_ld_in) begin
      h_data  <= in_data;
      h_sel   <= in_sel;
      h_carry <= in_carry;
      h_zero  <= in_zero;
      h_neg   <= in_neg;
    end else if (head_ld_e1) begin
      h_data  <= e1_data;
      h_sel   <= e1_sel;
      h_carry <= e1_carry;
      h_zero  <= e1_zero;
      h_neg   <= e1_neg;
    end else if (head_clr) begin
      h_data  <= '0;
      h_sel   <= '0;
      h_carry <= 1'b0;
      h_zero  <= 1'b0;
      h_neg   <= 1'b0;
    end
  end

  // Second (skid) entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_data  <= '0;
      e1_sel   <= '0;
      e1_carry <= 1'b0;
      e1_zero  <= 1'b0;
      e1_neg   <= 1'b0;
    end else if (e1_ld) begin
      e1_data  <= in_data;
      e1_sel   <= in_sel;
      e1_carry <= in_carry;
      e1_zero  <= in_zero;
      e1_neg   <= in_neg;
    end else if (e1_clr) begin
      e1_data  <= '0;
      e1_sel   <= '0;
      e1_carry <= 1'b0;
      e1_zero  <= 1'b0;
      e1_neg   <= 1'b0;
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  // Parity bit per entry, tracking the same load/promote/clear controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_par  <= 1'b0;
      e1_par <= 1'b0;
    end else begin
      if (head_ld_in)      h_par <= in_par;
      else if (head_ld_e1) h_par <= e1_par;
      else if (head_clr)   h_par <= 1'b0;
      if (e1_ld)           e1_par <= in_par;
      else if (e1_clr)     e1_par <= 1'b0;
    end
  end

  assign out_parity = h_par;
`endif

  // Pop counter, wraps modulo 2**CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + CNT_W'(1);
  end

  assign out_data  = h_data;
  assign out_sel   = h_sel;
  assign out_carry = h_carry;
  assign out_zero  = h_zero;
  assign out_neg   = h_neg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: main instance (CNT_W=8) plus a
// CNT_W=2 instance for counter wrap. Inputs change 1ns after posedge,
// outputs are checked at that point (registered values settled).
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_carry;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       out_valid, out_ready, out_zero, out_neg, out_carry;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [7:0] xfer_count;

  logic       w_in_valid, w_in_ready, w_in_carry;
  logic [7:0] w_in_data;
  logic [1:0] w_in_sel;
  logic       w_out_valid, w_out_ready, w_out_zero, w_out_neg, w_out_carry;
  logic [7:0] w_out_data;
  logic [1:0] w_out_sel;
  logic [1:0] w_xfer_count;
`ifdef ALU_RESULT_PARITY_EN
  logic       out_parity, w_out_parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .xfer_count(xfer_count)
`ifdef ALU_RESULT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  alu_result_stage #(.W(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_sel(w_in_sel), .in_carry(w_in_carry),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_sel(w_out_sel), .out_zero(w_out_zero), .out_neg(w_out_neg),
    .out_carry(w_out_carry), .xfer_count(w_xfer_count)
`ifdef ALU_RESULT_PARITY_EN
    , .out_parity(w_out_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_sel = '0; in_carry = 0; out_ready = 0;
    w_in_valid = 0; w_in_data = '0; w_in_sel = '0; w_in_carry = 0; w_out_ready = 0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // single push of zero, popped immediately
    in_valid = 1; in_data = 8'h00; in_sel = 2'b00; in_carry = 0; out_ready = 1;
    tick();
    in_valid = 0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'h00);
    chk("single_zero", out_zero, 1);
    chk("single_neg", out_neg, 0);
    tick();
    chk("single_xfer", xfer_count, 1);
    chk("single_empty", out_valid, 0);
    chk("single_zero_clr", out_zero, 0);

    // backpressure: fill both slots, third push refused
    out_ready = 0;
    in_valid = 1; in_data = 8'h85; in_sel = 2'b01; in_carry = 1;
    tick();
    chk("bp_ready_one", in_ready, 1);
    in_data = 8'h10; in_sel = 2'b10; in_carry = 0;
    tick();
    chk("bp_ready_full", in_ready, 0);
    in_data = 8'hFF; in_sel = 2'b11; in_carry = 1;
    tick();
    chk("bp_head_data", out_data, 8'h85);
    chk("bp_head_sel", out_sel, 2'b01);
    chk("bp_head_neg", out_neg, 1);
    chk("bp_head_carry", out_carry, 1);
    chk("bp_still_full", in_ready, 0);
`ifdef ALU_RESULT_PARITY_EN
    chk("bp_parity", out_parity, 1);
`endif

    // drain in order
    in_valid = 0; out_ready = 1;
    tick();
    chk("drain_data2", out_data, 8'h10);
    chk("drain_sel2", out_sel, 2'b10);
    chk("drain_neg2", out_neg, 0);
    chk("drain_valid2", out_valid, 1);
    chk("drain_ready2", in_ready, 1);
    tick();
    chk("drain_empty", out_valid, 0);
    chk("drain_data0", out_data, 8'h00);
    chk("drain_xfer", xfer_count, 3);

    // streaming push&pop at ONE
    in_valid = 1; in_sel = 2'b11; in_carry = 0;
    for (int i = 1; i <= 20; i++) begin
      in_data = 8'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), out_data, i);
      chk($sformatf("stream_ready_%0d", i), in_ready, 1);
    end
    in_valid = 0;
    tick();
    chk("stream_empty", out_valid, 0);
    chk("stream_xfer", xfer_count, 23);

    // counter wrap on the CNT_W=2 instance
    w_in_valid = 1; w_in_data = 8'h07; w_in_sel = 2'b01; w_out_ready = 1;
    tick();
    chk("wrap_head", w_out_data, 8'h07);
`ifdef ALU_RESULT_PARITY_EN
    chk("wrap_parity", w_out_parity, 1);
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("wrap_xfer_%0d", k), w_xfer_count, k % 4);
    end
    w_in_valid = 0;

    // mid-stream async reset with two entries held
    out_ready = 0;
    in_valid = 1; in_data = 8'hA1; in_sel = 2'b01;
    tick();
    in_data = 8'hB2;
    tick();
    in_valid = 0;
    chk("mid_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_xfer", xfer_count, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_neg", out_neg, 0);
    chk("mid_rst_wxfer", w_xfer_count, 0);
    tick();
    rst_n = 1'b1;
    in_valid = 1; in_data = 8'h42; in_sel = 2'b10;
    tick();
    in_valid = 0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
